// File: rtl/pe_pkg.sv
// -----------------------------------------------------------------------------
// pe_pkg -- shared definitions for the pe_mac_acc processing element.
//   * default operand / guard / counter widths
//   * accumulator width helper (AW = N + M + G)
//   * FSM state encoding
// No ports (package).
// -----------------------------------------------------------------------------
package pe_pkg;

  localparam int DEF_N  = 32;  // multiplicand width
  localparam int DEF_M  = 11;  // multiplier width
  localparam int DEF_G  = 8;   // accumulator guard bits
  localparam int DEF_CW = 16;  // beat counter / k_len width

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_HOLD = 2'd2
  } pe_state_e;

  // Accumulator width: full product width plus guard bits.
  function automatic int acc_width(input int n, input int m, input int g);
    return n + m + g;
  endfunction

endpackage

// File: rtl/pe_mac_acc_if.sv
// -----------------------------------------------------------------------------
// pe_mac_acc_if -- operand bus, dot-product control and result handshake of one
// processing element.
//   start/k_len          : dot-product request and beat count
//   in_valid/a_in/b_in   : operand pair from west/north neighbours
//   a_out/b_out/out_valid: operands forwarded east/south (one-cycle delay)
//   acc_out/acc_valid    : result, accepted by acc_ready
//   busy                 : element is in ACC or HOLD
// Modports: master (environment / neighbour side), slave (the PE).
// -----------------------------------------------------------------------------
interface pe_mac_acc_if #(
  parameter int N  = pe_pkg::DEF_N,
  parameter int M  = pe_pkg::DEF_M,
  parameter int G  = pe_pkg::DEF_G,
  parameter int CW = pe_pkg::DEF_CW
);
  localparam int AW = pe_pkg::acc_width(N, M, G);

  logic          start;
  logic [CW-1:0] k_len;
  logic          in_valid;
  logic [N-1:0]  a_in;
  logic [M-1:0]  b_in;
  logic [N-1:0]  a_out;
  logic [M-1:0]  b_out;
  logic          out_valid;
  logic [AW-1:0] acc_out;
  logic          acc_valid;
  logic          acc_ready;
  logic          busy;

  modport master (
    output start, k_len, in_valid, a_in, b_in, acc_ready,
    input  a_out, b_out, out_valid, acc_out, acc_valid, busy
  );

  modport slave (
    input  start, k_len, in_valid, a_in, b_in, acc_ready,
    output a_out, b_out, out_valid, acc_out, acc_valid, busy
  );

endinterface

// File: rtl/Array_MUL_USign.sv
// -----------------------------------------------------------------------------
// Array_MUL_USign -- combinational unsigned array multiplier.
//   a_i : N-bit multiplicand
//   b_i : M-bit multiplier
//   p_o : (N+M)-bit product
// One partial-product row per multiplier bit, rows summed by a linear chain.
// -----------------------------------------------------------------------------
module Array_MUL_USign #(
  parameter int N = 32,
  parameter int M = 11
) (
  input  logic [N-1:0]   a_i,
  input  logic [M-1:0]   b_i,
  output logic [N+M-1:0] p_o
);

  localparam int PW = N + M;

  logic [PW-1:0] row [M];
  logic [PW-1:0] sum;

  // Partial product row gi: multiplicand gated by multiplier bit gi, weighted 2^gi.
  for (genvar gi = 0; gi < M; gi++) begin : g_row
    assign row[gi] = b_i[gi] ? (PW'(a_i) << gi) : '0;
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < M; i++) begin
      sum = sum + row[i];
    end
  end

  assign p_o = sum;

endmodule

// File: rtl/pe_mac_acc.sv
// -----------------------------------------------------------------------------
// pe_mac_acc -- systolic-array processing element: forwards operands east/south
// with one cycle of latency and accumulates a k_len-beat dot product.
//   clk  : clock, all state on rising edge
//   rst  : synchronous active-high reset
//   bus  : pe_mac_acc_if.slave (control, operands, forwarded operands, result)
// FSM: IDLE -> (start) -> ACC -> (last beat) -> HOLD -> (acc_valid & acc_ready)
//      -> IDLE.  start with k_len == 0 goes straight to HOLD with a zero result.
// Build option: define PE_MAC_SAT_EN to saturate the accumulator at all-ones
// instead of wrapping modulo 2^AW.
// -----------------------------------------------------------------------------
module pe_mac_acc
  import pe_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int M  = DEF_M,
  parameter int G  = DEF_G,
  parameter int CW = DEF_CW
) (
  input  logic         clk,
  input  logic         rst,
  pe_mac_acc_if.slave  bus
);

  localparam int AW = acc_width(N, M, G);
  localparam int PW = N + M;

  pe_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [AW-1:0] acc_sum;
  logic [PW-1:0] prod;

  logic [N-1:0]  a_out_q;
  logic [M-1:0]  b_out_q;
  logic          out_valid_q;

  Array_MUL_USign #(
    .N (N),
    .M (M)
  ) u_mul (
    .a_i (bus.a_in),
    .b_i (bus.b_in),
    .p_o (prod)
  );

`ifdef PE_MAC_SAT_EN
  // One extra bit captures the carry-out; once clamped, every further add
  // of a non-zero product carries again, so the value sticks at all-ones.
  logic [AW:0] sum_wide;
  assign sum_wide = {1'b0, acc_q} + {1'b0, AW'(prod)};
  assign acc_sum  = sum_wide[AW] ? {AW{1'b1}} : sum_wide[AW-1:0];
`else
  assign acc_sum = acc_q + AW'(prod);
`endif

  // Next-state, counter and accumulator logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          acc_d = '0;
          if (bus.k_len != '0) begin
            cnt_d   = bus.k_len;
            state_d = ST_ACC;
          end else begin
            state_d = ST_HOLD;
          end
        end
      end
      ST_ACC: begin
        if (bus.in_valid) begin
          acc_d = acc_sum;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        // acc_valid is implied by HOLD, so acc_ready alone completes the handshake.
        if (bus.acc_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
    end
  end

  // Neighbour pass-through, independent of the FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_out_q     <= '0;
      b_out_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      a_out_q     <= bus.a_in;
      b_out_q     <= bus.b_in;
      out_valid_q <= bus.in_valid;
    end
  end

  assign bus.a_out     = a_out_q;
  assign bus.b_out     = b_out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.acc_out   = acc_q;
  assign bus.acc_valid = (state_q == ST_HOLD);
  assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pe_mac_acc.sv
// -----------------------------------------------------------------------------
// tb_pe_mac_acc -- self-checking bench for pe_mac_acc. A default-size element
// and a small N=4/M=4/G=0 element (overflow behaviour) share clk and rst.
// Expected results come from a sum-of-products model over queues of operands.
// -----------------------------------------------------------------------------
module tb_pe_mac_acc;
  import pe_pkg::*;

  localparam int N   = 32;
  localparam int M   = 11;
  localparam int G   = 8;
  localparam int CW  = 16;
  localparam int AW  = acc_width(N, M, G);
  localparam int SN  = 4;
  localparam int SM  = 4;
  localparam int SG  = 0;
  localparam int SAW = acc_width(SN, SM, SG);
`ifdef PE_MAC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pe_mac_acc_if #(.N(N),  .M(M),  .G(G),  .CW(CW)) bus  ();
  pe_mac_acc_if #(.N(SN), .M(SM), .G(SG), .CW(CW)) sbus ();

  pe_mac_acc #(.N(N),  .M(M),  .G(G),  .CW(CW)) dut   (.clk(clk), .rst(rst), .bus(bus));
  pe_mac_acc #(.N(SN), .M(SM), .G(SG), .CW(CW)) dut_s (.clk(clk), .rst(rst), .bus(sbus));

  int n_checks = 0;
  int n_errors = 0;

  // Reference: plain sum of products, wrapped or clamped at 2^aw after each add.
  function automatic longint unsigned ref_dot(input longint unsigned av[$],
                                              input longint unsigned bv[$],
                                              input int aw, input bit sat);
    longint unsigned lim;
    longint unsigned sum;
    lim = 64'd1 << aw;
    sum = 0;
    foreach (av[i]) begin
      sum = sum + av[i] * bv[i];
      if (sum >= lim) sum = sat ? (lim - 1) : (sum % lim);
    end
    return sum;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.start = 1'b0;  bus.k_len = '0;  bus.in_valid = 1'b0;
    bus.a_in = '0;     bus.b_in = '0;   bus.acc_ready = 1'b0;
    sbus.start = 1'b0; sbus.k_len = '0; sbus.in_valid = 1'b0;
    sbus.a_in = '0;    sbus.b_in = '0;  sbus.acc_ready = 1'b0;
  endtask

  task automatic test_reset;
    idle_inputs();
    rst = 1'b1;
    bus.start = 1'b1; bus.k_len = 16'd3; bus.in_valid = 1'b1;
    bus.a_in = $urandom | 32'h1; bus.b_in = M'($urandom) | 11'h1;
    repeat (3) tick();
    n_checks++;
    if ({bus.acc_valid, bus.busy, bus.out_valid} !== 3'b000) begin
      n_errors++;
      $display("FAIL reset_flags: got %b expected 000", {bus.acc_valid, bus.busy, bus.out_valid});
    end
    n_checks++;
    if (bus.acc_out !== '0) begin
      n_errors++;
      $display("FAIL reset_acc_out: got %0d expected 0", bus.acc_out);
    end
    n_checks++;
    if (bus.a_out !== '0 || bus.b_out !== '0) begin
      n_errors++;
      $display("FAIL reset_fwd: got a=%0d b=%0d expected 0/0", bus.a_out, bus.b_out);
    end
    idle_inputs();
    rst = 1'b0;
    tick();
    $display("reset: outputs cleared");
  endtask

  task automatic test_spec_example;
    longint unsigned aq[$];
    longint unsigned bq[$];
    longint unsigned exp_acc;
    aq = {64'd5, 64'd10, 64'd1};
    bq = {64'd7, 64'd3, 64'd2047};
    exp_acc = ref_dot(aq, bq, AW, SAT);
    bus.start = 1'b1; bus.k_len = 16'd3;
    tick();
    bus.start = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b1 || bus.acc_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL example_enter_acc: got busy=%b valid=%b expected 1/0", bus.busy, bus.acc_valid);
    end
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1; bus.a_in = N'(aq[i]); bus.b_in = M'(bq[i]);
      tick();
      if (i < 2) begin
        n_checks++;
        if (bus.acc_valid !== 1'b0) begin
          n_errors++;
          $display("FAIL example_early_valid: got %b expected 0 after beat %0d", bus.acc_valid, i);
        end
      end
    end
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.acc_valid !== 1'b1 || bus.acc_out !== AW'(exp_acc)) begin
      n_errors++;
      $display("FAIL example_result: got valid=%b acc=%0d expected 1/%0d", bus.acc_valid, bus.acc_out, exp_acc);
    end
    bus.acc_ready = 1'b1;
    tick();
    bus.acc_ready = 1'b0;
    n_checks++;
    if (bus.acc_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_errors++;
      $display("FAIL example_release: got valid=%b busy=%b expected 0/0", bus.acc_valid, bus.busy);
    end
    $display("example: k=3 acc_out=%0d", bus.acc_out);
  endtask

  task automatic test_zero_len;
    bus.start = 1'b1; bus.k_len = '0;
    tick();
    bus.start = 1'b0;
    n_checks++;
    if (bus.acc_valid !== 1'b1 || bus.acc_out !== '0 || bus.busy !== 1'b1) begin
      n_errors++;
      $display("FAIL zero_len_hold: got valid=%b acc=%0d busy=%b expected 1/0/1",
               bus.acc_valid, bus.acc_out, bus.busy);
    end
    tick();
    n_checks++;
    if (bus.acc_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL zero_len_stay: got valid=%b expected 1", bus.acc_valid);
    end
    bus.acc_ready = 1'b1;
    tick();
    bus.acc_ready = 1'b0;
    n_checks++;
    if (bus.acc_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_errors++;
      $display("FAIL zero_len_release: got valid=%b busy=%b expected 0/0", bus.acc_valid, bus.busy);
    end
    $display("zero_len: k=0 acc_out=0 released");
  endtask

  task automatic test_gaps_hold;
    longint unsigned aq[$];
    longint unsigned bq[$];
    longint unsigned exp_acc;
    aq.push_back(longint'($urandom)); bq.push_back(longint'($urandom_range(0, 2047)));
    aq.push_back(longint'($urandom)); bq.push_back(longint'($urandom_range(0, 2047)));
    exp_acc = ref_dot(aq, bq, AW, SAT);
    bus.start = 1'b1; bus.k_len = 16'd2;
    tick();
    // gap with a stray start and junk operands
    bus.start = 1'b1; bus.k_len = 16'd9; bus.in_valid = 1'b0;
    bus.a_in = $urandom; bus.b_in = M'($urandom);
    tick();
    bus.start = 1'b0; bus.in_valid = 1'b1; bus.a_in = N'(aq[0]); bus.b_in = M'(bq[0]);
    tick();
    bus.start = 1'b1; bus.in_valid = 1'b0; bus.a_in = $urandom; bus.b_in = M'($urandom);
    tick();
    n_checks++;
    if (bus.acc_valid !== 1'b0 || bus.busy !== 1'b1) begin
      n_errors++;
      $display("FAIL gaps_count: got valid=%b busy=%b expected 0/1 after one beat", bus.acc_valid, bus.busy);
    end
    bus.start = 1'b0; bus.in_valid = 1'b1; bus.a_in = N'(aq[1]); bus.b_in = M'(bq[1]);
    tick();
    n_checks++;
    if (bus.acc_valid !== 1'b1 || bus.acc_out !== AW'(exp_acc)) begin
      n_errors++;
      $display("FAIL gaps_result: got valid=%b acc=%0d expected 1/%0d", bus.acc_valid, bus.acc_out, exp_acc);
    end
    for (int c = 0; c < 5; c++) begin
      bus.start = c[0]; bus.k_len = 16'd4; bus.in_valid = 1'b1;
      bus.a_in = $urandom | 32'h1; bus.b_in = M'($urandom) | 11'h1;
      tick();
      n_checks++;
      if (bus.acc_valid !== 1'b1 || bus.acc_out !== AW'(exp_acc)) begin
        n_errors++;
        $display("FAIL hold_stable: cycle %0d got valid=%b acc=%0d expected 1/%0d",
                 c, bus.acc_valid, bus.acc_out, exp_acc);
      end
    end
    // handshake together with a start that must be ignored
    bus.in_valid = 1'b0; bus.acc_ready = 1'b1; bus.start = 1'b1; bus.k_len = 16'd5;
    tick();
    bus.acc_ready = 1'b0; bus.start = 1'b0;
    n_checks++;
    if (bus.acc_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_errors++;
      $display("FAIL hold_release: got valid=%b busy=%b expected 0/0", bus.acc_valid, bus.busy);
    end
    tick();
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_errors++;
      $display("FAIL start_in_hold_ignored: got busy=%b expected 0", bus.busy);
    end
    $display("gaps_hold: k=2 acc_out=%0d", exp_acc);
  endtask

  task automatic test_wrap;
    longint unsigned aq[$];
    longint unsigned bq[$];
    longint unsigned exp_acc;
    aq = {64'd15, 64'd15};
    bq = {64'd15, 64'd15};
    exp_acc = ref_dot(aq, bq, SAW, SAT);
    sbus.start = 1'b1; sbus.k_len = 16'd2;
    tick();
    sbus.start = 1'b0; sbus.in_valid = 1'b1; sbus.a_in = 4'd15; sbus.b_in = 4'd15;
    repeat (2) tick();
    sbus.in_valid = 1'b0;
    n_checks++;
    if (sbus.acc_valid !== 1'b1 || sbus.acc_out !== SAW'(exp_acc)) begin
      n_errors++;
      $display("FAIL wrap_result: got valid=%b acc=%0d expected 1/%0d", sbus.acc_valid, sbus.acc_out, exp_acc);
    end
    sbus.acc_ready = 1'b1;
    tick();
    sbus.acc_ready = 1'b0;
    $display("wrap: 15*15 x2 acc_out=%0d", exp_acc);
  endtask

  task automatic test_rst_mid;
    bus.start = 1'b1; bus.k_len = 16'd3;
    tick();
    bus.start = 1'b0; bus.in_valid = 1'b1; bus.a_in = $urandom | 32'h1; bus.b_in = 11'd5;
    tick();
    rst = 1'b1;
    tick();
    n_checks++;
    if ({bus.acc_valid, bus.busy, bus.out_valid} !== 3'b000 || bus.acc_out !== '0 ||
        bus.a_out !== '0 || bus.b_out !== '0) begin
      n_errors++;
      $display("FAIL rst_mid: got valid=%b busy=%b ov=%b acc=%0d a=%0d b=%0d expected all 0",
               bus.acc_valid, bus.busy, bus.out_valid, bus.acc_out, bus.a_out, bus.b_out);
    end
    rst = 1'b0; bus.in_valid = 1'b0; bus.start = 1'b1; bus.k_len = 16'd1;
    tick();
    bus.start = 1'b0; bus.in_valid = 1'b1; bus.a_in = 32'd3; bus.b_in = 11'd4;
    tick();
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.acc_valid !== 1'b1 || bus.acc_out !== AW'(12)) begin
      n_errors++;
      $display("FAIL rst_restart: got valid=%b acc=%0d expected 1/12", bus.acc_valid, bus.acc_out);
    end
    bus.acc_ready = 1'b1;
    tick();
    bus.acc_ready = 1'b0;
    $display("rst_mid: abandoned, restart k=1 acc_out=12");
  endtask

  task automatic test_random_dots;
    for (int t = 0; t < 20; t++) begin
      longint unsigned aq[$];
      longint unsigned bq[$];
      longint unsigned exp_acc;
      int k;
      k = $urandom_range(1, 8);
      for (int i = 0; i < k; i++) begin
        aq.push_back(longint'($urandom));
        bq.push_back(longint'($urandom_range(0, 2047)));
      end
      exp_acc = ref_dot(aq, bq, AW, SAT);
      bus.start = 1'b1; bus.k_len = CW'(k);
      tick();
      bus.start = 1'b0;
      for (int i = 0; i < k; i++) begin
        while ($urandom_range(0, 99) < 30) begin
          bus.in_valid = 1'b0; bus.a_in = $urandom; bus.b_in = M'($urandom);
          tick();
        end
        bus.in_valid = 1'b1; bus.a_in = N'(aq[i]); bus.b_in = M'(bq[i]);
        tick();
      end
      bus.in_valid = 1'b0;
      repeat ($urandom_range(0, 3)) tick();
      n_checks++;
      if (bus.acc_valid !== 1'b1 || bus.acc_out !== AW'(exp_acc)) begin
        n_errors++;
        $display("FAIL random_dot: t=%0d k=%0d got valid=%b acc=%0d expected 1/%0d",
                 t, k, bus.acc_valid, bus.acc_out, exp_acc);
      end
      bus.acc_ready = 1'b1;
      tick();
      bus.acc_ready = 1'b0;
      $display("random_dot: t=%0d k=%0d acc_out=%0d", t, k, exp_acc);
    end
  endtask

  task automatic test_passthrough;
    logic [N-1:0] pa;
    logic [M-1:0] pb;
    logic         pv;
    int           bad;
    bad = 0;
    for (int c = 0; c < 300; c++) begin
      bus.in_valid  = 1'($urandom);
      bus.a_in      = $urandom;
      bus.b_in      = M'($urandom);
      bus.start     = ($urandom_range(0, 9) == 0);
      bus.k_len     = CW'($urandom_range(0, 4));
      bus.acc_ready = 1'($urandom);
      pa = bus.a_in; pb = bus.b_in; pv = bus.in_valid;
      tick();
      n_checks++;
      if (bus.a_out !== pa || bus.b_out !== pb || bus.out_valid !== pv) begin
        n_errors++;
        bad++;
        $display("FAIL passthrough: cycle %0d got a=%0d b=%0d v=%b expected a=%0d b=%0d v=%b",
                 c, bus.a_out, bus.b_out, bus.out_valid, pa, pb, pv);
      end
    end
    idle_inputs();
    $display("passthrough: 300 cycles, %0d bad", bad);
  endtask

  initial begin
    test_reset();
    test_spec_example();
    test_zero_len();
    test_gaps_hold();
    test_wrap();
    test_rst_mid();
    test_random_dots();
    test_passthrough();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1);
  end

endmodule
